ray_column_scheduler: RTL and testbench

Issues the per-frame sequence of screen column indices to the ray-calculation stage(s) over AXI-stream-style valid/ready handshakes, and replaces the free-running column counter that previously fed ray calculation with no flow control. It distributes columns across `NUM_LANES` parallel ray/DDA lanes. It bounds in-flight work with a credit counter that is returned by the frame-buffer write side, and signals when a complete frame of columns has been retired. It sits between the video timing generator (frame start) and the ray-calculation front ends.

---
 rtl/raycast_pkg.sv | 16 +
 rtl/credit_counter.sv | 47 ++++
 rtl/ray_column_scheduler.sv | 126 ++++++++++++
 tb/tb_ray_column_scheduler.sv | 426 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/raycast_pkg.sv
// Shared raycaster definitions: scheduler states and screen geometry.
package raycast_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } sched_state_t;

  localparam int unsigned SCREEN_WIDTH  = 320;
  localparam int unsigned SCREEN_HEIGHT = 240;

  // Width of the in-flight column credit count.
  localparam int unsigned CREDIT_W = 8;

endpackage

// File: rtl/credit_counter.sv
// Saturating in-flight credit counter: inc on issue, dec on retire.
// A dec at zero is dropped and reported on underflow.
module credit_counter
  import raycast_pkg::*;
#(
  parameter int unsigned MAX_COUNT = 16
) (
  input  logic                clk_pixel,
  input  logic                rst_n,
  input  logic                inc,
  input  logic                dec,
  output logic [CREDIT_W-1:0] count,
  output logic                at_max,
  output logic                underflow
);

  logic [CREDIT_W-1:0] count_q;
  logic [CREDIT_W-1:0] count_d;
  logic                inc_ok;
  logic                dec_ok;

  // Next count; simultaneous inc and valid dec cancel out.
  always_comb begin
    inc_ok  = inc && (count_q != '1);
    dec_ok  = dec && (count_q != '0);
    count_d = count_q;
    case ({inc_ok, dec_ok})
      2'b10:   count_d = count_q + CREDIT_W'(1);
      2'b01:   count_d = count_q - CREDIT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Credit count register.
  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count     = count_q;
  assign at_max    = (count_q >= CREDIT_W'(MAX_COUNT));
  assign underflow = dec && (count_q == '0);

endmodule

// File: rtl/ray_column_scheduler.sv
// Issues one frame of column indices to NUM_LANES ray lanes over
// valid/ready, bounded by a retire-returned credit count.
module ray_column_scheduler #(
  parameter int unsigned SCREEN_WIDTH    = raycast_pkg::SCREEN_WIDTH,
  parameter int unsigned NUM_LANES       = 1,
  parameter int unsigned HCOUNT_W        = 9,
  parameter int unsigned MAX_OUTSTANDING = 16
) (
  input  logic                          pixel_clk_in,
  input  logic                          rst_in,
  input  logic                          frame_start_in,
  output logic [NUM_LANES-1:0]          col_tvalid_out,
  input  logic [NUM_LANES-1:0]          col_tready_in,
  output logic [NUM_LANES*HCOUNT_W-1:0] col_tdata_out,
  output logic [NUM_LANES-1:0]          col_tlast_out,
  input  logic                          retire_in,
  output logic                          busy_out,
  output logic [7:0]                    outstanding_out,
  output logic                          frame_done_out,
  output logic                          overrun_out
);

  import raycast_pkg::*;

  localparam logic [HCOUNT_W-1:0] LAST_COL  = HCOUNT_W'(SCREEN_WIDTH - 1);
  localparam logic [HCOUNT_W-1:0] LANE_MASK = HCOUNT_W'(NUM_LANES - 1);

  sched_state_t        state_q, state_d;
  logic [HCOUNT_W-1:0] next_col_q, next_col_d;
  logic [HCOUNT_W-1:0] lane_idx;
  logic                frame_done_q, frame_done_d;
  logic                overrun_q, overrun_d;
  logic                issue_ok;
  logic                is_last;
  logic                handshake;
  logic [7:0]          outstanding;
  logic                at_max;
  logic                underflow;

  credit_counter #(
    .MAX_COUNT (MAX_OUTSTANDING)
  ) u_credit (
    .clk_pixel (pixel_clk_in),
    .rst_n     (rst_in),
    .inc       (handshake),
    .dec       (retire_in),
    .count     (outstanding),
    .at_max    (at_max),
    .underflow (underflow)
  );

  // Lane steering. Valid depends only on registered state, and the count
  // can only grow through this lane's own handshake, so a raised valid
  // holds until accepted without needing a separate hold register.
  always_comb begin
    lane_idx       = next_col_q & LANE_MASK;
    issue_ok       = (state_q == ISSUE) && !at_max;
    is_last        = (next_col_q == LAST_COL);
    col_tvalid_out = '0;
    col_tlast_out  = '0;
    col_tdata_out  = '0;
    handshake      = 1'b0;
    for (int unsigned k = 0; k < NUM_LANES; k++) begin
      if (lane_idx == HCOUNT_W'(k)) begin
        if (state_q == ISSUE) begin
          col_tdata_out[k*HCOUNT_W +: HCOUNT_W] = next_col_q;
        end
        col_tvalid_out[k] = issue_ok;
        col_tlast_out[k]  = issue_ok && is_last;
        handshake         = issue_ok && col_tready_in[k];
      end
    end
  end

  // Frame sequencing, column advance and error flag.
  always_comb begin
    state_d      = state_q;
    next_col_d   = next_col_q;
    frame_done_d = 1'b0;
    overrun_d    = overrun_q || underflow || (frame_start_in && (state_q != IDLE));
    case (state_q)
      IDLE: begin
        if (frame_start_in) begin
          state_d    = ISSUE;
          next_col_d = '0;
        end
      end
      ISSUE: begin
        if (handshake) begin
          next_col_d = next_col_q + HCOUNT_W'(1);
          if (is_last) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (outstanding == '0) begin
          frame_done_d = 1'b1;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and flag registers.
  always_ff @(posedge pixel_clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q      <= IDLE;
      next_col_q   <= '0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      next_col_q   <= next_col_d;
      frame_done_q <= frame_done_d;
      overrun_q    <= overrun_d;
    end
  end

  assign busy_out        = (state_q != IDLE);
  assign outstanding_out = outstanding;
  assign frame_done_out  = frame_done_q;
  assign overrun_out     = overrun_q;

endmodule

// File: tb/tb_ray_column_scheduler.sv
// Bench for ray_column_scheduler: two lanes, 320 columns, 16 credits.
module tb_ray_column_scheduler;

  localparam int SW    = 320;
  localparam int NL    = 2;
  localparam int HW    = 9;
  localparam int MAXO  = 16;
  localparam int OBS_W = NL + NL*HW + NL + 1 + 8 + 1 + 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic             retire;
  logic [NL-1:0]    ready;
  logic [NL-1:0]    valid;
  logic [NL-1:0]    last;
  logic [NL*HW-1:0] data;
  logic             busy;
  logic [7:0]       outst;
  logic             done;
  logic             over;

  always #5 clk = ~clk;

  ray_column_scheduler #(
    .SCREEN_WIDTH    (SW),
    .NUM_LANES       (NL),
    .HCOUNT_W        (HW),
    .MAX_OUTSTANDING (MAXO)
  ) dut (
    .pixel_clk_in    (clk),
    .rst_in          (rst_n),
    .frame_start_in  (start),
    .col_tvalid_out  (valid),
    .col_tready_in   (ready),
    .col_tdata_out   (data),
    .col_tlast_out   (last),
    .retire_in       (retire),
    .busy_out        (busy),
    .outstanding_out (outst),
    .frame_done_out  (done),
    .overrun_out     (over)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model: frame in progress, columns handed out, credits, flags.
  bit m_in_frame, m_over, m_done, m_hs;
  int m_next, m_out;
  int accepted[$];
  int acc_lane[$];

  function automatic logic [OBS_W-1:0] model_obs();
    logic [NL-1:0]    v;
    logic [NL-1:0]    l;
    logic [NL*HW-1:0] d;
    int               lane;
    v    = '0;
    l    = '0;
    d    = '0;
    lane = m_next % NL;
    if (m_in_frame && m_next < SW) begin
      d[lane*HW +: HW] = HW'(m_next);
      v[lane]          = (m_out < MAXO);
      l[lane]          = v[lane] && (m_next == SW - 1);
    end
    return {v, d, l, m_in_frame, 8'(m_out), m_done, m_over};
  endfunction

  function automatic logic [OBS_W-1:0] dut_obs();
    return {valid, data, last, busy, outst, done, over};
  endfunction

  task automatic model_reset();
    m_in_frame = 0; m_over = 0; m_done = 0; m_hs = 0;
    m_next = 0; m_out = 0;
  endtask

  // One clock: drive inputs at the falling edge, log DUT handshakes,
  // advance the model, and return at the next falling edge.
  task automatic step(input logic st, input logic [NL-1:0] rdy, input logic ret);
    int lane;
    bit hs, ret_ok, fin;
    start  = st;
    ready  = rdy;
    retire = ret;
    #1;
    for (int k = 0; k < NL; k++) begin
      if (valid[k] && rdy[k]) begin
        accepted.push_back(int'(data[k*HW +: HW]));
        acc_lane.push_back(k);
      end
    end
    lane   = m_next % NL;
    hs     = m_in_frame && (m_next < SW) && (m_out < MAXO) && rdy[lane];
    ret_ok = ret && (m_out > 0);
    fin    = m_in_frame && (m_next == SW) && (m_out == 0);
    if ((ret && m_out == 0) || (st && m_in_frame)) m_over = 1;
    m_out  = m_out + int'(hs) - int'(ret_ok);
    m_hs   = hs;
    if (hs) m_next++;
    m_done = fin;
    if (fin) m_in_frame = 0;
    else if (!m_in_frame && st) begin
      m_in_frame = 1;
      m_next     = 0;
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
    start  = 1'b0;
    retire = 1'b0;
  endtask

  task automatic reset_dut();
    rst_n  = 1'b0;
    start  = 1'b0;
    retire = 1'b0;
    ready  = '0;
    model_reset();
    accepted.delete();
    acc_lane.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    start  = 1'b0;
    retire = 1'b0;
    ready  = '1;
    model_reset();
    #12;
    checks++;
    if (dut_obs() !== '0) begin
      errors++;
      $display("FAIL reset_values: got %h expected 0", dut_obs());
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (dut_obs() !== model_obs()) begin
      errors++;
      $display("FAIL after_reset: got %h expected %h", dut_obs(), model_obs());
    end
  endtask

  task automatic test_credit_stall();
    int n;
    accepted.delete();
    acc_lane.delete();
    step(1'b1, '1, 1'b0);
    for (int i = 0; i < 20; i++) begin
      step(1'b0, '1, 1'b0);
      checks++;
      if (dut_obs() !== model_obs()) begin
        errors++;
        if (errors < 30) $display("FAIL stall_cycle %0d: got %h expected %h", i, dut_obs(), model_obs());
      end
    end
    checks++;
    if (outst !== 8'd16 || valid !== '0) begin
      errors++;
      $display("FAIL stall_hold: got outstanding %0d valid %b expected 16 and 00", outst, valid);
    end
    checks++;
    if (accepted.size() != 16) begin
      errors++;
      $display("FAIL stall_count: got %0d columns expected 16", accepted.size());
    end else begin
      for (int i = 0; i < 16; i++) begin
        if (accepted[i] != i) begin
          errors++;
          $display("FAIL stall_order: got column %0d expected %0d", accepted[i], i);
          break;
        end
      end
    end
    n = 0;
    while (!m_done && n < 2000) begin
      step(1'b0, '1, m_out > 0);
      n++;
      checks++;
      if (dut_obs() !== model_obs()) begin
        errors++;
        if (errors < 30) $display("FAIL stall_drain cycle %0d: got %h expected %h", n, dut_obs(), model_obs());
      end
    end
    if (!m_done) begin
      errors++;
      $display("FAIL stall_drain_timeout: got no frame end expected one");
    end
  endtask

  task automatic test_lanes_retire2();
    bit rp0, rp1, ret;
    int n, last_ret, done_cyc;
    rp0 = 0; rp1 = 0; n = 0; last_ret = -100; done_cyc = -1;
    accepted.delete();
    acc_lane.delete();
    step(1'b1, '1, 1'b0);
    while (!m_done && n < 2000) begin
      ret = rp1;
      if (ret) last_ret = cyc;
      step(1'b0, '1, ret);
      rp1 = rp0;
      rp0 = m_hs;
      n++;
      if (done && done_cyc < 0) done_cyc = cyc;
      checks++;
      if (dut_obs() !== model_obs()) begin
        errors++;
        if (errors < 30) $display("FAIL lanes_cycle %0d: got %h expected %h", n, dut_obs(), model_obs());
      end
    end
    checks++;
    if (done_cyc != last_ret + 2) begin
      errors++;
      $display("FAIL done_timing: got cycle %0d expected %0d", done_cyc, last_ret + 2);
    end
    checks++;
    if (accepted.size() != SW) begin
      errors++;
      $display("FAIL lanes_count: got %0d columns expected %0d", accepted.size(), SW);
    end else begin
      for (int i = 0; i < SW; i++) begin
        if (accepted[i] != i || acc_lane[i] != i % NL) begin
          errors++;
          $display("FAIL lanes_order: got column %0d lane %0d expected %0d lane %0d",
                   accepted[i], acc_lane[i], i, i % NL);
          break;
        end
      end
    end
    // A new frame is accepted in the same cycle frame_done is high.
    step(1'b1, '1, 1'b0);
    checks++;
    if (busy !== 1'b1 || valid !== 2'b01 || dut_obs() !== model_obs()) begin
      errors++;
      $display("FAIL back_to_back: got %h expected %h", dut_obs(), model_obs());
    end
  endtask

  task automatic test_backpressure();
    logic [NL-1:0]    pv, pr;
    logic [NL*HW-1:0] pd;
    logic [NL-1:0]    pl;
    logic [NL-1:0]    rdy;
    int n;
    reset_dut();
    step(1'b1, '0, 1'b0);
    n = 0;
    while (!m_done && n < 6000) begin
      pv  = valid; pd = data; pl = last;
      rdy = NL'($urandom);
      pr  = rdy;
      step(1'b0, rdy, (m_out > 0) && ($urandom_range(0, 1) == 1));
      n++;
      checks++;
      if (dut_obs() !== model_obs()) begin
        errors++;
        if (errors < 30) $display("FAIL bp_cycle %0d: got %h expected %h", n, dut_obs(), model_obs());
      end
      if ((pv & ~pr) != '0) begin
        checks++;
        if ({valid, data, last} !== {pv, pd, pl}) begin
          errors++;
          if (errors < 30) $display("FAIL bp_stable cycle %0d: got %h expected %h", n, {valid, data, last}, {pv, pd, pl});
        end
      end
    end
    checks++;
    if (accepted.size() != SW) begin
      errors++;
      $display("FAIL bp_count: got %0d columns expected %0d", accepted.size(), SW);
    end else begin
      for (int i = 0; i < SW; i++) begin
        if (accepted[i] != i) begin
          errors++;
          $display("FAIL bp_order: got column %0d expected %0d", accepted[i], i);
          break;
        end
      end
    end
  endtask

  task automatic test_overrun();
    bit rp0, rp1, ret, seen_done;
    int n;
    reset_dut();
    step(1'b0, '0, 1'b1);
    checks++;
    if (over !== 1'b1 || dut_obs() !== model_obs()) begin
      errors++;
      $display("FAIL overrun_retire: got %h expected %h", dut_obs(), model_obs());
    end
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0);
    checks++;
    if (over !== 1'b1) begin
      errors++;
      $display("FAIL overrun_sticky: got %b expected 1", over);
    end
    reset_dut();
    rp0 = 0; rp1 = 0; n = 0; seen_done = 0;
    step(1'b1, '1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      ret = rp1;
      step(1'b0, '1, ret);
      rp1 = rp0; rp0 = m_hs;
    end
    checks++;
    if (over !== 1'b0) begin
      errors++;
      $display("FAIL overrun_clear: got %b expected 0", over);
    end
    ret = rp1;
    step(1'b1, '1, ret);
    rp1 = rp0; rp0 = m_hs;
    checks++;
    if (over !== 1'b1 || dut_obs() !== model_obs()) begin
      errors++;
      $display("FAIL overrun_start: got %h expected %h", dut_obs(), model_obs());
    end
    while (!m_done && n < 2000) begin
      ret = rp1;
      step(1'b0, '1, ret);
      rp1 = rp0; rp0 = m_hs;
      n++;
      if (done) seen_done = 1;
      checks++;
      if (dut_obs() !== model_obs()) begin
        errors++;
        if (errors < 30) $display("FAIL overrun_cycle %0d: got %h expected %h", n, dut_obs(), model_obs());
      end
    end
    checks++;
    if (!seen_done || over !== 1'b1 || accepted.size() != SW) begin
      errors++;
      $display("FAIL overrun_frame: got done %b overrun %b columns %0d expected 1 1 %0d",
               seen_done, over, accepted.size(), SW);
    end
  endtask

  task automatic test_reset_mid_frame();
    bit rp0, rp1, ret;
    int n;
    reset_dut();
    rp0 = 0; rp1 = 0; n = 0;
    step(1'b1, '1, 1'b0);
    while (m_next < 100 && n < 1000) begin
      ret = rp1;
      step(1'b0, '1, ret);
      rp1 = rp0; rp0 = m_hs;
      n++;
    end
    checks++;
    if (dut_obs() !== model_obs() || busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_frame_pre: got %h expected %h", dut_obs(), model_obs());
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (dut_obs() !== '0) begin
      errors++;
      $display("FAIL mid_frame_reset: got %h expected 0", dut_obs());
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    step(1'b1, '0, 1'b0);
    checks++;
    if (valid !== 2'b01 || data[HW-1:0] !== '0 || dut_obs() !== model_obs()) begin
      errors++;
      $display("FAIL mid_frame_restart: got %h expected %h", dut_obs(), model_obs());
    end
  endtask

  task automatic test_same_cycle();
    reset_dut();
    step(1'b1, '0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, '1, 1'b0);
    step(1'b0, '0, 1'b0);
    checks++;
    if (outst !== 8'd5 || dut_obs() !== model_obs()) begin
      errors++;
      $display("FAIL same_pre: got outstanding %0d expected 5", outst);
    end
    step(1'b0, '1, 1'b1);
    checks++;
    if (outst !== 8'd5) begin
      errors++;
      $display("FAIL same_cycle: got outstanding %0d expected 5", outst);
    end
    checks++;
    if (dut_obs() !== model_obs() || valid !== 2'b01 || data[HW-1:0] !== 9'd6) begin
      errors++;
      $display("FAIL same_next: got %h expected %h", dut_obs(), model_obs());
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_credit_stall();
    test_lanes_retire2();
    test_backpressure();
    test_overrun();
    test_reset_mid_frame();
    test_same_cycle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
